// File: rtl/ddma_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ddma_release_scheduler
// Description : Table-driven packet release scheduler for one PE. Holds
//               NUM_DESC descriptors (target XY, payload bytes, release time,
//               optional period). When the lowest-indexed due descriptor is
//               found, it writes the header flit and the size flit into PE
//               memory at BUF_BASE / BUF_BASE+1, then pulses a DDMA send
//               command and waits for completion.
// Ports       : clock, reset (async, active-low)
//               start_in                 - zero time counter, set running
//               cfg_*                    - descriptor write port
//               mem_*_out                - PE local memory write port
//               ddma_*_out, ddma_done_in - DDMA command / completion
//               busy_out                 - scheduler not idle
//               late_count_out           - packets issued after release time
// Revision    : 1.0 - initial release
// ============================================================================
module ddma_release_scheduler #(
  parameter int FLIT_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIME_WIDTH = 32,
  parameter int NUM_DESC   = 8,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int BUF_BASE   = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_in,
  input  logic                        cfg_we_in,
  input  logic [$clog2(NUM_DESC)-1:0] cfg_idx_in,
  input  logic [FLIT_WIDTH/4-1:0]     cfg_tx_in,
  input  logic [FLIT_WIDTH/4-1:0]     cfg_ty_in,
  input  logic [15:0]                 cfg_bytes_in,
  input  logic [TIME_WIDTH-1:0]       cfg_release_in,
  input  logic [TIME_WIDTH-1:0]       cfg_period_in,
  output logic                        mem_enable_out,
  output logic                        mem_wb_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr_out,
  output logic [FLIT_WIDTH-1:0]       mem_data_out,
  output logic                        ddma_cmd_out,
  output logic [ADDR_WIDTH-1:0]       ddma_addr_out,
  output logic [15:0]                 ddma_nbytes_out,
  input  logic                        ddma_done_in,
  output logic                        busy_out,
  output logic [15:0]                 late_count_out
);

  localparam int IDX_W = $clog2(NUM_DESC);
  localparam int QW    = FLIT_WIDTH / 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_SIZE  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] C_HDR_ADDR  = ADDR_WIDTH'(BUF_BASE);
  localparam logic [ADDR_WIDTH-1:0] C_SIZE_ADDR = ADDR_WIDTH'(BUF_BASE + 1);
  localparam logic [QW-1:0]         C_SRC_X     = QW'(SRC_X);
  localparam logic [QW-1:0]         C_SRC_Y     = QW'(SRC_Y);

  // Descriptor table
  logic [NUM_DESC-1:0]   r_valid;
  logic [QW-1:0]         r_tx     [NUM_DESC];
  logic [QW-1:0]         r_ty     [NUM_DESC];
  logic [15:0]           r_bytes  [NUM_DESC];
  logic [TIME_WIDTH-1:0] r_rel    [NUM_DESC];
  logic [TIME_WIDTH-1:0] r_period [NUM_DESC];

  // Time base
  logic                  r_running;
  logic [TIME_WIDTH-1:0] r_time;

  // In-flight packet (latched copy of the selected descriptor)
  logic [2:0]            r_state;
  logic [IDX_W-1:0]      r_sel_idx;
  logic [15:0]           r_sel_bytes;
  logic [TIME_WIDTH-1:0] r_sel_rel;
  logic [TIME_WIDTH-1:0] r_sel_period;
  logic                  r_sel_late;
  // Set when the in-flight entry is rewritten before ISSUE; the new
  // programming must then survive the ISSUE-time re-arm / invalidate.
  logic                  r_dirty;

  // Registered outputs
  logic                  r_wb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [FLIT_WIDTH-1:0] r_data;
  logic                  r_cmd;
  logic [ADDR_WIDTH-1:0] r_dma_addr;
  logic [15:0]           r_nbytes;
  logic                  r_busy;
  logic [15:0]           r_late;

  logic                  w_any_due;
  logic [IDX_W-1:0]      w_due_idx;
  logic [FLIT_WIDTH-1:0] w_hdr;
  logic [15:0]           w_sz;
  logic                  w_cfg_hit_due;
  logic                  w_cfg_hit_sel;

  // Lowest due index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    w_any_due = 1'b0;
    w_due_idx = '0;
    for (int i = NUM_DESC - 1; i >= 0; i--) begin
      if (r_valid[i] && r_running && (r_rel[i] <= r_time)) begin
        w_any_due = 1'b1;
        w_due_idx = IDX_W'(i);
      end
    end
  end

  assign w_hdr = FLIT_WIDTH'({C_SRC_X, C_SRC_Y, r_tx[w_due_idx], r_ty[w_due_idx]});

  // Size in flits: ceil(bytes/4) payload flits plus the size flit itself.
  assign w_sz = 16'(r_sel_bytes[15:2]) + 16'(|r_sel_bytes[1:0]) + 16'd1;

  assign w_cfg_hit_due = cfg_we_in && (cfg_idx_in == w_due_idx);
  assign w_cfg_hit_sel = cfg_we_in && (cfg_idx_in == r_sel_idx);

  // Time base
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_running <= 1'b0;
      r_time    <= '0;
    end else if (start_in) begin
      r_running <= 1'b1;
      r_time    <= '0;
    end else if (r_running && (r_time != '1)) begin
      r_time    <= r_time + 1'b1;
    end
  end

  // Descriptor table; the cfg write is placed last so it overrides the
  // ISSUE-time update of the same entry in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_DESC; i++) begin
        r_tx[i]     <= '0;
        r_ty[i]     <= '0;
        r_bytes[i]  <= '0;
        r_rel[i]    <= '0;
        r_period[i] <= '0;
      end
    end else begin
      if ((r_state == S_ISSUE) && !r_dirty) begin
        if (r_sel_period == '0) begin
          r_valid[r_sel_idx] <= 1'b0;
        end else begin
          r_rel[r_sel_idx] <= r_sel_rel + r_sel_period;
        end
      end
      if (cfg_we_in) begin
        r_valid[cfg_idx_in]  <= (cfg_bytes_in != 16'd0);
        r_tx[cfg_idx_in]     <= cfg_tx_in;
        r_ty[cfg_idx_in]     <= cfg_ty_in;
        r_bytes[cfg_idx_in]  <= cfg_bytes_in;
        r_rel[cfg_idx_in]    <= cfg_release_in;
        r_period[cfg_idx_in] <= cfg_period_in;
      end
    end
  end

  // Sequencer and registered outputs. Strobes/data default to 0 each cycle
  // so they are asserted only in the state that uses them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sel_idx    <= '0;
      r_sel_bytes  <= '0;
      r_sel_rel    <= '0;
      r_sel_period <= '0;
      r_sel_late   <= 1'b0;
      r_dirty      <= 1'b0;
      r_wb         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cmd        <= 1'b0;
      r_dma_addr   <= '0;
      r_nbytes     <= '0;
      r_busy       <= 1'b0;
      r_late       <= '0;
    end else begin
      r_wb       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cmd      <= 1'b0;
      r_dma_addr <= '0;
      r_nbytes   <= '0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (w_any_due) begin
            r_state      <= S_HDR;
            r_busy       <= 1'b1;
            r_sel_idx    <= w_due_idx;
            r_sel_bytes  <= r_bytes[w_due_idx];
            r_sel_rel    <= r_rel[w_due_idx];
            r_sel_period <= r_period[w_due_idx];
            r_sel_late   <= (r_time > r_rel[w_due_idx]);
            r_dirty      <= w_cfg_hit_due;
            r_wb         <= 1'b1;
            r_addr       <= C_HDR_ADDR;
            r_data       <= w_hdr;
          end
        end
        S_HDR: begin
          r_state <= S_SIZE;
          r_dirty <= r_dirty | w_cfg_hit_sel;
          r_wb    <= 1'b1;
          r_addr  <= C_SIZE_ADDR;
          r_data  <= FLIT_WIDTH'(w_sz);
        end
        S_SIZE: begin
          r_state    <= S_ISSUE;
          r_dirty    <= r_dirty | w_cfg_hit_sel;
          r_cmd      <= 1'b1;
          r_dma_addr <= C_HDR_ADDR;
          r_nbytes   <= w_sz + 16'd2;
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          if (r_sel_late && (r_late != 16'hFFFF)) begin
            r_late <= r_late + 16'd1;
          end
        end
        S_WAIT: begin
          if (ddma_done_in) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_enable_out  = r_running;
  assign mem_wb_out      = r_wb;
  assign mem_addr_out    = r_addr;
  assign mem_data_out    = r_data;
  assign ddma_cmd_out    = r_cmd;
  assign ddma_addr_out   = r_dma_addr;
  assign ddma_nbytes_out = r_nbytes;
  assign busy_out        = r_busy;
  assign late_count_out  = r_late;

endmodule
`default_nettype wire

// File: tb/tb_ddma_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddma_release_scheduler
// Description : Self-checking bench for ddma_release_scheduler. A one-shot
//               packet is checked cycle by cycle from a vector table; the
//               multi-cycle scenarios (ordering, collision, periodic,
//               reset abort, in-flight rewrite) are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddma_release_scheduler;

  localparam int BASE = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_in = 1'b0;
  logic        cfg_we_in = 1'b0;
  logic [2:0]  cfg_idx_in = '0;
  logic [3:0]  cfg_tx_in = '0;
  logic [3:0]  cfg_ty_in = '0;
  logic [15:0] cfg_bytes_in = '0;
  logic [31:0] cfg_release_in = '0;
  logic [31:0] cfg_period_in = '0;
  logic        mem_enable_out;
  logic        mem_wb_out;
  logic [15:0] mem_addr_out;
  logic [15:0] mem_data_out;
  logic        ddma_cmd_out;
  logic [15:0] ddma_addr_out;
  logic [15:0] ddma_nbytes_out;
  logic        ddma_done_in = 1'b0;
  logic        busy_out;
  logic [15:0] late_count_out;

  ddma_release_scheduler #(
    .FLIT_WIDTH(16), .ADDR_WIDTH(16), .TIME_WIDTH(32), .NUM_DESC(8),
    .SRC_X(0), .SRC_Y(0), .BUF_BASE(BASE)
  ) dut (
    .clock(clock), .reset(reset), .start_in(start_in),
    .cfg_we_in(cfg_we_in), .cfg_idx_in(cfg_idx_in),
    .cfg_tx_in(cfg_tx_in), .cfg_ty_in(cfg_ty_in),
    .cfg_bytes_in(cfg_bytes_in), .cfg_release_in(cfg_release_in),
    .cfg_period_in(cfg_period_in),
    .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .ddma_cmd_out(ddma_cmd_out), .ddma_addr_out(ddma_addr_out),
    .ddma_nbytes_out(ddma_nbytes_out), .ddma_done_in(ddma_done_in),
    .busy_out(busy_out), .late_count_out(late_count_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int t_start  = 0;

  // Values written by capture() when asked to rewrite the in-flight entry.
  logic [2:0]  rw_idx;
  logic [3:0]  rw_tx, rw_ty;
  logic [15:0] rw_bytes;
  logic [31:0] rw_rel, rw_per;

  typedef struct {
    logic        start;
    logic        we;
    logic [2:0]  idx;
    logic [3:0]  tx;
    logic [3:0]  ty;
    logic [15:0] bytes;
    logic [31:0] rel;
    logic [31:0] per;
    logic        done;
    logic        e_men;
    logic        e_wb;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic        e_cmd;
    logic [15:0] e_daddr;
    logic [15:0] e_nb;
    logic        e_busy;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [3:0] tx, input logic [3:0] ty,
                     input logic [15:0] bytes, input logic [31:0] rel, input logic [31:0] per);
    cfg_we_in = 1'b1; cfg_idx_in = idx; cfg_tx_in = tx; cfg_ty_in = ty;
    cfg_bytes_in = bytes; cfg_release_in = rel; cfg_period_in = per;
    @(posedge clock); @(negedge clock);
    cfg_we_in = 1'b0;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    @(posedge clock); @(negedge clock);
    start_in = 1'b0;
    t_start = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Called at the sample point of the cmd cycle; raises done dly cycles later.
  task automatic send_done(input int dly);
    repeat (dly) @(negedge clock);
    ddma_done_in = 1'b1;
    @(negedge clock);
    ddma_done_in = 1'b0;
  endtask

  task automatic capture(input int limit, input bit rewrite,
                         output logic [15:0] hdr, output logic [15:0] sz,
                         output logic [15:0] nb, output int tcmd, output bit ok);
    hdr = '0; sz = '0; nb = '0; tcmd = -1; ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(posedge clock); @(negedge clock);
      cfg_we_in = 1'b0;
      if (mem_wb_out && mem_addr_out == 16'(BASE)) begin
        hdr = mem_data_out;
        if (rewrite) begin
          cfg_we_in = 1'b1; cfg_idx_in = rw_idx; cfg_tx_in = rw_tx; cfg_ty_in = rw_ty;
          cfg_bytes_in = rw_bytes; cfg_release_in = rw_rel; cfg_period_in = rw_per;
        end
      end
      if (mem_wb_out && mem_addr_out == 16'(BASE + 1)) sz = mem_data_out;
      if (ddma_cmd_out) begin
        nb = ddma_nbytes_out;
        tcmd = cyc - t_start;
        ok = 1'b1;
      end
    end
  endtask

  task automatic pkt(input string nm, input int limit, input bit rw,
                     input logic [15:0] ehdr, input logic [15:0] esz,
                     input logic [15:0] enb, input int et);
    logic [15:0] h, s, n;
    int t;
    bit ok;
    capture(limit, rw, h, s, n, t, ok);
    chk({nm, "_cmd_seen"}, 32'(ok), 32'd1);
    chk({nm, "_hdr"}, 32'(h), 32'(ehdr));
    chk({nm, "_size"}, 32'(s), 32'(esz));
    chk({nm, "_nbytes"}, 32'(n), 32'(enb));
    chk({nm, "_cmd_time"}, 32'(t), 32'(et));
  endtask

  task automatic quiet(input int n, input string nm);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); @(negedge clock);
      if (mem_wb_out || ddma_cmd_out) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st we idx tx ty bytes rel per dn | men wb addr  data   cmd daddr nb busy
    vt[0] = '{0, 1, 0, 1, 1, 52, 0, 0, 0,        0,  0, 0,    0,     0,  0,    0,  0};
    vt[1] = '{1, 0, 0, 0, 0, 0,  0, 0, 0,        1,  0, 0,    0,     0,  0,    0,  0};
    vt[2] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,        1,  1, BASE, 16'h0011, 0, 0,  0,  1};
    vt[3] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,        1,  1, BASE+1, 14,  0,  0,    0,  1};
    vt[4] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,        1,  0, 0,    0,     1,  BASE, 16, 1};
    vt[5] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,        1,  0, 0,    0,     0,  0,    0,  1};
    vt[6] = '{0, 0, 0, 0, 0, 0,  0, 0, 1,        1,  0, 0,    0,     0,  0,    0,  0};
    vt[7] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,        1,  0, 0,    0,     0,  0,    0,  0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_mem_enable", 32'(mem_enable_out), 0);
    chk("rst_wb", 32'(mem_wb_out), 0);
    chk("rst_addr", 32'(mem_addr_out), 0);
    chk("rst_data", 32'(mem_data_out), 0);
    chk("rst_cmd", 32'(ddma_cmd_out), 0);
    chk("rst_nbytes", 32'(ddma_nbytes_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_late", 32'(late_count_out), 0);
    reset = 1'b1;
    @(negedge clock);

    // T1: one-shot packet, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      start_in = vt[i].start; cfg_we_in = vt[i].we; cfg_idx_in = vt[i].idx;
      cfg_tx_in = vt[i].tx; cfg_ty_in = vt[i].ty; cfg_bytes_in = vt[i].bytes;
      cfg_release_in = vt[i].rel; cfg_period_in = vt[i].per; ddma_done_in = vt[i].done;
      @(posedge clock); @(negedge clock);
      chk($sformatf("t1_v%0d_men", i), 32'(mem_enable_out), 32'(vt[i].e_men));
      chk($sformatf("t1_v%0d_wb", i), 32'(mem_wb_out), 32'(vt[i].e_wb));
      if (vt[i].e_wb) chk($sformatf("t1_v%0d_addr", i), 32'(mem_addr_out), 32'(vt[i].e_addr));
      chk($sformatf("t1_v%0d_data", i), 32'(mem_data_out), 32'(vt[i].e_data));
      chk($sformatf("t1_v%0d_cmd", i), 32'(ddma_cmd_out), 32'(vt[i].e_cmd));
      chk($sformatf("t1_v%0d_daddr", i), 32'(ddma_addr_out), 32'(vt[i].e_daddr));
      chk($sformatf("t1_v%0d_nbytes", i), 32'(ddma_nbytes_out), 32'(vt[i].e_nb));
      chk($sformatf("t1_v%0d_busy", i), 32'(busy_out), 32'(vt[i].e_busy));
    end
    start_in = 1'b0; cfg_we_in = 1'b0; ddma_done_in = 1'b0;
    quiet(8, "t1_entry_invalid");
    chk("t1_late", 32'(late_count_out), 0);

    // T2: lowest due first, later release honoured; bytes=0 invalidates
    do_reset();
    cfg(0, 1, 0, 20, 36, 0);
    cfg(1, 0, 1, 16, 0, 0);
    cfg(7, 2, 2, 12, 0, 0);
    cfg(7, 2, 2, 0, 0, 0);
    do_start();
    pkt("t2_e1", 10, 0, 16'h0001, 5, 7, 3);
    send_done(1);
    pkt("t2_e0", 60, 0, 16'h0010, 6, 8, 39);
    send_done(1);
    quiet(20, "t2_no_extra");
    chk("t2_late", 32'(late_count_out), 0);

    // T3: collision at the same release time
    do_reset();
    cfg(2, 3, 1, 9, 10, 0);
    cfg(5, 1, 3, 1, 10, 0);
    do_start();
    pkt("t3_e2", 20, 0, 16'h0031, 4, 6, 13);
    send_done(1);
    chk("t3_late_after_e2", 32'(late_count_out), 0);
    pkt("t3_e5", 20, 0, 16'h0013, 2, 4, 18);
    send_done(1);
    chk("t3_late_after_e5", 32'(late_count_out), 1);

    // T4: periodic descriptor
    do_reset();
    cfg(0, 2, 2, 4, 5, 20);
    do_start();
    pkt("t4_p0", 20, 0, 16'h0022, 2, 4, 8);
    send_done(2);
    pkt("t4_p1", 30, 0, 16'h0022, 2, 4, 28);
    send_done(2);
    pkt("t4_p2", 30, 0, 16'h0022, 2, 4, 48);
    send_done(2);
    chk("t4_late", 32'(late_count_out), 0);

    // T5: reset asserted while waiting for done
    do_reset();
    cfg(0, 1, 2, 8, 20, 0);
    do_start();
    pkt("t5_pkt", 40, 0, 16'h0012, 3, 5, 23);
    @(negedge clock);
    chk("t5_busy_in_wait", 32'(busy_out), 1);
    reset = 1'b0;
    #1;
    chk("t5_abort_men", 32'(mem_enable_out), 0);
    chk("t5_abort_busy", 32'(busy_out), 0);
    chk("t5_abort_wb", 32'(mem_wb_out), 0);
    chk("t5_abort_cmd", 32'(ddma_cmd_out), 0);
    @(negedge clock);
    reset = 1'b1;
    quiet(40, "t5_no_cmd_after_release");
    chk("t5_men_after_release", 32'(mem_enable_out), 0);
    do_start();
    quiet(40, "t5_no_cmd_after_restart");

    // T6: rewrite of the in-flight entry during HDR
    do_reset();
    cfg(3, 2, 3, 40, 4, 0);
    rw_idx = 3; rw_tx = 4; rw_ty = 5; rw_bytes = 8; rw_rel = 30; rw_per = 0;
    do_start();
    pkt("t6_old", 20, 1, 16'h0023, 11, 13, 7);
    send_done(1);
    pkt("t6_new", 40, 0, 16'h0045, 3, 5, 33);
    send_done(1);
    quiet(10, "t6_oneshot_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
